// File: rtl/dma_perf_monitor.sv
// dma_perf_monitor: saturating beat/byte/stall/latency/cycle counters for the DMA AXI engine.
// Define DMA_PERF_OVF_IRQ_EN to add the sticky overflow interrupt (ovf_irq/ovf_ack).
module dma_perf_monitor #(
  parameter int NUM_PORTS  = 1,
  parameter int NUM_PERIPH = 1,
  parameter int DATA_W     = 64,
  parameter int CNT_W      = 32,
  parameter int SEL_W      = 8
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          mon_start,
  input  logic                          mon_stop,
  input  logic                          mon_clear,
  input  logic [NUM_PORTS*DATA_W/8-1:0] wstrb,
  input  logic [NUM_PORTS-1:0]          wvalid,
  input  logic [NUM_PORTS-1:0]          wready,
  input  logic [NUM_PORTS-1:0]          rvalid,
  input  logic [NUM_PORTS-1:0]          rready,
  input  logic [NUM_PERIPH-1:0]         periph_tx_req,
  input  logic [NUM_PERIPH-1:0]         periph_tx_clr,
  input  logic [NUM_PERIPH-1:0]         periph_rx_req,
  input  logic [NUM_PERIPH-1:0]         periph_rx_clr,
  input  logic [SEL_W-1:0]              cnt_sel,
  output logic [CNT_W-1:0]              cnt_rdata,
  output logic                          mon_running
`ifdef DMA_PERF_OVF_IRQ_EN
  ,
  output logic                          ovf_irq,
  input  logic                          ovf_ack
`endif
);

  localparam int SW   = DATA_W / 8;
  localparam int NLAT = NUM_PERIPH * 2;
  localparam int BASE = NUM_PORTS * 5;
  localparam int CYC  = BASE + NLAT;
  localparam int NCNT = CYC + 1;
  localparam logic [CNT_W-1:0] MAXV = '1;
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FROZEN
  } state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0] cnt     [NCNT];
  logic [CNT_W-1:0] cnt_nxt [NCNT];
  logic [CNT_W-1:0] lat     [NLAT];
  logic [NLAT-1:0]  lreq;
  logic [NLAT-1:0]  lclr;
  logic [NLAT-1:0]  pend;
  logic [CNT_W-1:0] rd_nxt;
  logic             run;

  assign run         = (state == RUN);
  assign mon_running = run;

  function automatic logic [CNT_W-1:0] sat_add(
    input logic [CNT_W-1:0] a,
    input logic [CNT_W-1:0] b
  );
    logic [CNT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CNT_W] ? MAXV : s[CNT_W-1:0];
  endfunction

  function automatic logic [CNT_W-1:0] popcnt(
    input logic [SW-1:0] s
  );
    logic [CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < SW; i++) begin
      if (s[i]) n = n + ONE;
    end
    return n;
  endfunction

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    priority case (1'b1)
      mon_clear: state_nxt = IDLE;
      mon_stop:  if (run) state_nxt = FROZEN;
      mon_start: if (!run) state_nxt = RUN;
      default:   state_nxt = state;
    endcase
  end

  // tracker j = q*2 + dir (dir 0 = tx, 1 = rx) matches the readback layout
  always_comb begin
    lreq = '0;
    lclr = '0;
    for (int q = 0; q < NUM_PERIPH; q++) begin
      lreq[q*2]   = periph_tx_req[q];
      lreq[q*2+1] = periph_rx_req[q];
      lclr[q*2]   = periph_tx_clr[q];
      lclr[q*2+1] = periph_rx_clr[q];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pend <= '0;
      for (int j = 0; j < NLAT; j++) lat[j] <= '0;
    end else begin
      for (int j = 0; j < NLAT; j++) begin
        if (mon_clear) begin
          pend[j] <= 1'b0;
          lat[j]  <= '0;
        end else if (pend[j]) begin
          if (lclr[j]) pend[j] <= 1'b0;
          else         lat[j]  <= sat_add(lat[j], ONE);
        end else if (lreq[j] && !lclr[j]) begin
          pend[j] <= 1'b1;
          lat[j]  <= ONE;
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NCNT; i++) cnt_nxt[i] = cnt[i];
    if (run) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (wvalid[p] && wready[p]) begin
          cnt_nxt[p*5]   = sat_add(cnt[p*5], ONE);
          cnt_nxt[p*5+1] = sat_add(cnt[p*5+1],
                                   popcnt(wstrb[p*SW +: SW]));
        end
        if (wvalid[p] && !wready[p])
          cnt_nxt[p*5+2] = sat_add(cnt[p*5+2], ONE);
        if (rvalid[p] && rready[p])
          cnt_nxt[p*5+3] = sat_add(cnt[p*5+3], ONE);
        if (rvalid[p] && !rready[p])
          cnt_nxt[p*5+4] = sat_add(cnt[p*5+4], ONE);
      end
      for (int j = 0; j < NLAT; j++) begin
        if (lclr[j] && pend[j] && (lat[j] > cnt[BASE+j]))
          cnt_nxt[BASE+j] = lat[j];
      end
      cnt_nxt[CYC] = sat_add(cnt[CYC], ONE);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NCNT; i++) cnt[i] <= '0;
    end else if (mon_clear) begin
      for (int i = 0; i < NCNT; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NCNT; i++) cnt[i] <= cnt_nxt[i];
    end
  end

  // out-of-range selects fall through to zero
  always_comb begin
    rd_nxt = '0;
    for (int i = 0; i < NCNT; i++) begin
      if (cnt_sel == SEL_W'(i)) rd_nxt = cnt[i];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) cnt_rdata <= '0;
    else       cnt_rdata <= rd_nxt;
  end

`ifdef DMA_PERF_OVF_IRQ_EN
  logic reach;

  always_comb begin
    reach = 1'b0;
    for (int i = 0; i < NCNT; i++) begin
      if ((cnt_nxt[i] == MAXV) && (cnt[i] != MAXV)) reach = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)          ovf_irq <= 1'b0;
    else if (mon_clear) ovf_irq <= 1'b0;
    else if (reach)     ovf_irq <= 1'b1;
    else if (ovf_ack)   ovf_irq <= 1'b0;
  end
`endif

endmodule
